// File: rtl/cv32e40p_register_file_scrubber.sv
// Background ECC scrubber for the Hamming-protected register file (32 data bits, 38-bit codeword).
// Optional error log (err_count_o / last_err_addr_o) is built only when SCRUB_ERR_LOG_EN is defined.
module cv32e40p_register_file_scrubber #(
  parameter int NUM_WORDS      = 32,
  parameter int SCRUB_INTERVAL = 1024,
  localparam int ADDR_W        = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scrub_en_i,
  input  logic              core_rd_busy_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_waddr_i,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       dec_data_i,
  input  logic              dec_fault_i,
  output logic              wr_req_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [37:0]       wr_codeword_o,
  input  logic              wr_gnt_i,
  output logic              sweep_done_o,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] last_err_addr_o
);

  localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    ADVANCE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [37:0]       cw_q;
  logic              sample;
  logic              hazard;

  // Hamming encode: data fills non-power-of-two positions; parity at position 2^k
  // covers every position with bit k set, giving a zero syndrome.
  function automatic logic [37:0] encode(input logic [31:0] d);
    logic [37:0] cw;
    logic        p;
    int          j;
    cw = '0;
    j  = 0;
    for (int i = 0; i < 38; i++) begin
      if (((i + 1) & i) != 0) begin
        cw[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      p = 1'b0;
      for (int i = 0; i < 38; i++) begin
        if ((((i + 1) & i) != 0) && ((((i + 1) >> k) & 1) != 0)) p ^= cw[i];
      end
      cw[(1 << k) - 1] = p;
    end
    return cw;
  endfunction

  // A core write to the entry being repaired carries newer data, so the writeback is dropped.
  assign hazard = core_we_i && (core_waddr_i == ptr);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= FIRST_ADDR;
      cnt   <= '0;
      cw_q  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      if (sample) cw_q <= encode(dec_data_i);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    sample    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!scrub_en_i) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          state_nxt = READ;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      READ: begin
        if (!core_rd_busy_i) begin
          sample    = 1'b1;
          state_nxt = dec_fault_i ? WRITE : ADVANCE;
        end
      end
      WRITE: begin
        if (hazard || wr_gnt_i) state_nxt = ADVANCE;
      end
      ADVANCE: begin
        ptr_nxt   = (ptr == LAST_ADDR) ? FIRST_ADDR : ptr + ADDR_W'(1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_req_o      = (state == READ);
  assign rd_addr_o     = rd_req_o ? ptr : '0;
  assign wr_req_o      = (state == WRITE);
  assign wr_addr_o     = wr_req_o ? ptr : '0;
  assign wr_codeword_o = wr_req_o ? cw_q : '0;
  assign sweep_done_o  = (state == ADVANCE) && (ptr == LAST_ADDR);

`ifdef SCRUB_ERR_LOG_EN
  logic              log_en;
  logic [15:0]       err_count_q;
  logic [ADDR_W-1:0] last_err_q;

  assign log_en = (state == WRITE) && wr_gnt_i && !hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
      last_err_q  <= '0;
    end else if (log_en) begin
      if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      last_err_q <= ptr;
    end
  end

  assign err_count_o     = err_count_q;
  assign last_err_addr_o = last_err_q;
`else
  assign err_count_o     = '0;
  assign last_err_addr_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_register_file_scrubber.sv
// Directed bench for cv32e40p_register_file_scrubber; the bench plays the external decoder.
// Expected log outputs follow SCRUB_ERR_LOG_EN when it is defined for the build.
module tb_cv32e40p_register_file_scrubber;

  localparam int NUM_WORDS = 32;
  localparam int ADDR_W    = 5;
`ifdef SCRUB_ERR_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              scrub_en_i = 1'b0;
  logic              core_rd_busy_i = 1'b0;
  logic              core_we_i = 1'b0;
  logic [ADDR_W-1:0] core_waddr_i = '0;
  logic              rd_req_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [31:0]       dec_data_i;
  logic              dec_fault_i;
  logic              wr_req_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [37:0]       wr_codeword_o;
  logic              wr_gnt_i = 1'b0;
  logic              sweep_done_o;
  logic [15:0]       err_count_o;
  logic [ADDR_W-1:0] last_err_addr_o;

  logic              fault_on = 1'b0;
  logic [ADDR_W-1:0] fault_addr = ADDR_W'(5);

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rd = 0;
  int wr_seen = 0;
  int sweeps = 0;

  cv32e40p_register_file_scrubber #(
    .NUM_WORDS     (NUM_WORDS),
    .SCRUB_INTERVAL(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .scrub_en_i     (scrub_en_i),
    .core_rd_busy_i (core_rd_busy_i),
    .core_we_i      (core_we_i),
    .core_waddr_i   (core_waddr_i),
    .rd_req_o       (rd_req_o),
    .rd_addr_o      (rd_addr_o),
    .dec_data_i     (dec_data_i),
    .dec_fault_i    (dec_fault_i),
    .wr_req_o       (wr_req_o),
    .wr_addr_o      (wr_addr_o),
    .wr_codeword_o  (wr_codeword_o),
    .wr_gnt_i       (wr_gnt_i),
    .sweep_done_o   (sweep_done_o),
    .err_count_o    (err_count_o),
    .last_err_addr_o(last_err_addr_o)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: a busy read port returns junk flagged as faulty.
  assign dec_fault_i = (fault_on && (rd_addr_o == fault_addr)) || core_rd_busy_i;
  assign dec_data_i  = (rd_addr_o == fault_addr) ? 32'hDEADBEEF : {27'd0, rd_addr_o};

  function automatic logic [5:0] syndrome(input logic [37:0] cw);
    logic [5:0] s = '0;
    for (int i = 0; i < 38; i++) if (cw[i]) s ^= 6'(i + 1);
    return s;
  endfunction

  function automatic logic [31:0] extract(input logic [37:0] cw);
    logic [31:0] d = '0;
    int j = 0;
    for (int i = 0; i < 38; i++) begin
      if (((i + 1) & i) != 0) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (wr_req_o === 1'b1) wr_seen++;
    if (sweep_done_o === 1'b1) sweeps++;
  endtask

  task automatic wait_rd(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (rd_req_o !== 1'b1 && n < 50);
    check({tag, "_rd_seen"}, 64'(rd_req_o), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_req"},   64'(rd_req_o),        64'd0);
    check({tag, "_rd_addr"},  64'(rd_addr_o),       64'd0);
    check({tag, "_wr_req"},   64'(wr_req_o),        64'd0);
    check({tag, "_wr_addr"},  64'(wr_addr_o),       64'd0);
    check({tag, "_wr_cw"},    64'(wr_codeword_o),   64'd0);
    check({tag, "_sweep"},    64'(sweep_done_o),    64'd0);
    check({tag, "_err_cnt"},  64'(err_count_o),     64'd0);
    check({tag, "_last_err"}, 64'(last_err_addr_o), 64'd0);
  endtask

  initial begin
    bit found;
    int rd_seen;

    // Reset
    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;
    scrub_en_i = 1'b1;
    wr_seen = 0;
    sweeps = 0;

    // Clean sweep: one read every SCRUB_INTERVAL+2 = 6 cycles, addresses 1..31
    for (int a = 1; a < NUM_WORDS; a++) begin
      wait_rd("sweep");
      check("sweep_addr", 64'(rd_addr_o), 64'(a));
      if (a > 1) check("sweep_period", 64'(cyc - last_rd), 64'd6);
      last_rd = cyc;
    end
    check("sweep_done_early", 64'(sweeps), 64'd0);
    wait_rd("wrap");
    check("wrap_addr", 64'(rd_addr_o), 64'd1);
    check("wrap_period", 64'(cyc - last_rd), 64'd6);
    check("sweep_done_once", 64'(sweeps), 64'd1);
    check("clean_no_wr", 64'(wr_seen), 64'd0);

    // Faulty entry 5 with grant withheld for 3 cycles
    fault_on   = 1'b1;
    fault_addr = ADDR_W'(5);
    for (int a = 2; a <= 5; a++) begin
      wait_rd("to5");
      check("to5_addr", 64'(rd_addr_o), 64'(a));
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      check("wb_req",  64'(wr_req_o),                64'd1);
      check("wb_addr", 64'(wr_addr_o),               64'd5);
      check("wb_syn",  64'(syndrome(wr_codeword_o)), 64'd0);
      check("wb_data", 64'(extract(wr_codeword_o)),  64'hDEADBEEF);
      if (k == 4) wr_gnt_i = 1'b1;
    end
    step();
    wr_gnt_i = 1'b0;
    fault_on = 1'b0;
    check("wb_released", 64'(wr_req_o),        64'd0);
    check("wb_err_cnt",  64'(err_count_o),     LOG ? 64'd1 : 64'd0);
    check("wb_last_err", 64'(last_err_addr_o), LOG ? 64'd5 : 64'd0);

    // Walk around to entry 5 again, then collide with a core write (grant in same cycle)
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      wait_rd("to5b");
      if (rd_addr_o == ADDR_W'(5)) found = 1'b1;
    end
    check("to5b_found", 64'(found), 64'd1);
    fault_on = 1'b1;
    step();
    check("abort_wr_req", 64'(wr_req_o), 64'd1);
    core_we_i    = 1'b1;
    core_waddr_i = ADDR_W'(5);
    wr_gnt_i     = 1'b1;
    step();
    core_we_i = 1'b0;
    wr_gnt_i  = 1'b0;
    fault_on  = 1'b0;
    check("abort_dropped", 64'(wr_req_o),        64'd0);
    check("abort_err_cnt", 64'(err_count_o),     LOG ? 64'd1 : 64'd0);
    check("abort_last",    64'(last_err_addr_o), LOG ? 64'd5 : 64'd0);
    wait_rd("after_abort");
    check("after_abort_addr", 64'(rd_addr_o), 64'd6);

    // Read port busy for 5 cycles: retry same address, junk fault ignored
    core_rd_busy_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("busy_rd_req",  64'(rd_req_o),  64'd1);
      check("busy_rd_addr", 64'(rd_addr_o), 64'd6);
      if (k == 5) core_rd_busy_i = 1'b0;
    end
    step();
    check("busy_done_rd", 64'(rd_req_o), 64'd0);
    check("busy_no_wr",   64'(wr_req_o), 64'd0);
    wait_rd("after_busy");
    check("after_busy_addr", 64'(rd_addr_o), 64'd7);

    // Reset while a writeback is pending
    fault_on   = 1'b1;
    fault_addr = ADDR_W'(7);
    step();
    check("rst_wr_req", 64'(wr_req_o),  64'd1);
    check("rst_wr_adr", 64'(wr_addr_o), 64'd7);
    rst = 1'b1;
    step();
    check_idle_outputs("rst_mid");
    rst      = 1'b0;
    fault_on = 1'b0;
    wait_rd("post_rst");
    check("post_rst_addr", 64'(rd_addr_o), 64'd1);

    // Disable mid-read: the read completes, then the scrubber parks with pointer held
    scrub_en_i = 1'b0;
    rd_seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (rd_req_o === 1'b1) rd_seen++;
    end
    check("parked_no_rd", 64'(rd_seen), 64'd0);
    scrub_en_i = 1'b1;
    wait_rd("resume");
    check("resume_addr", 64'(rd_addr_o), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_register_file_scrubber.md
Name: cv32e40p_register_file_scrubber

Overview:
Background ECC scrubber for the Hamming-protected register file (32 data bits, 38-bit codeword).
- Walks register-file entries at a programmable interval.
- Reads each codeword through a spare read port and takes its result from an external decoder instance (corrected data plus fault flag).
- On a fault, re-encodes the corrected data and writes it back, so latent single-bit upsets cannot accumulate into uncorrectable double errors.
- Sits beside the register file; arbitrates against core accesses and always yields to the core.

Parameters:
NUM_WORDS, 32, register-file depth; address width is $clog2(NUM_WORDS).
SCRUB_INTERVAL, 1024, idle cycles between consecutive scrub reads (min 1).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
scrub_en_i  input  1  enables scrubbing
core_rd_busy_i  input  1  core is using the shared read port this cycle
core_we_i  input  1  core register-file write enable
core_waddr_i  input  ADDR_W  core write address
rd_req_o  output  1  scrubber owns the read port
rd_addr_o  output  ADDR_W  scrub read address
dec_data_i  input  32  corrected data from decoder (combinational from rd_addr_o)
dec_fault_i  input  1  decoder nonzero-syndrome flag
wr_req_o  output  1  scrub writeback request
wr_addr_o  output  ADDR_W  writeback address
wr_codeword_o  output  38  re-encoded codeword
wr_gnt_i  input  1  write port granted this cycle
sweep_done_o  output  1  one-cycle pulse at end of each full sweep
err_count_o  output  16  corrected-error counter (optional feature)
last_err_addr_o  output  ADDR_W  address of latest corrected error (optional feature)

Behaviour:
Reset values:
- State IDLE; pointer = 1; interval counter = 0.
- All outputs 0.
- Address 0 (x0) is never scrubbed.

IDLE:
- While scrub_en_i=0, the counter is held at 0.
- While enabled, the counter increments each cycle. At SCRUB_INTERVAL-1: clear the counter, go to READ.

READ:
- rd_req_o=1, rd_addr_o=pointer.
- If core_rd_busy_i=1: nothing sampled, stay in READ (retry).
- Otherwise, in the same cycle, sample dec_data_i into the data register and dec_fault_i into the fault flag.
- fault=1 → WRITE; fault=0 → ADVANCE.

WRITE:
- wr_req_o=1; wr_addr_o=pointer; wr_codeword_o = encode(data register), registered.
- Hold all three stable until wr_gnt_i=1, then → ADVANCE.
- Hazard: if core_we_i=1 and core_waddr_i==pointer in any WRITE cycle, abort the writeback. The core data is newer; drop wr_req_o next cycle and → ADVANCE without counting.
- If wr_gnt_i and the matching core write occur in the same cycle, the abort wins and wr_gnt_i is ignored.

Encoding (bit index i, 1-based position i+1):
- Parity bits sit at indices 0,1,3,7,15,31.
- Data bits d0..d31 fill the remaining indices in ascending order (d0 at 2, d31 at 37).
- Parity at index 2^k-1 = XOR of all data bits whose position has bit k set.
- The result must yield a zero syndrome in the decoder.

ADVANCE:
- Pointer = pointer+1; at NUM_WORDS-1 it wraps to 1 and sweep_done_o pulses for one cycle.
- → IDLE.

Other rules:
- scrub_en_i deassert mid-transaction: the current READ/WRITE completes; the scrubber then parks in IDLE with the pointer held.
- Latency with no contention: READ 1 cycle; WRITE ≥1 cycle; ADVANCE 1 cycle.
- Double-bit errors are not detected. The decoder miscorrects and the scrubber writes back its output unchanged.
- Reset in any state returns to reset values on the next edge; any pending wr_req_o drops.

Optional Feature:
SCRUB_ERR_LOG_EN
- Defined: err_count_o increments (saturating at 0xFFFF) on each granted writeback, and last_err_addr_o captures the pointer at the same time. Aborted writebacks change neither.
- Undefined: both outputs are tied to 0, and the counter/address registers are not implemented.

Test Plan:
- NUM_WORDS=32, SCRUB_INTERVAL=4, all entries clean, scrub_en_i=1 → rd_req_o every 6 cycles, addresses 1..31; sweep_done_o pulses after addr 31; pointer returns to 1; wr_req_o never asserted.
- Entry 5 holds data 0xDEADBEEF with codeword bit 12 flipped; decoder returns 0xDEADBEEF and fault=1 → wr_req_o at addr 5 with the correct codeword; with the feature enabled, err_count_o=1 and last_err_addr_o=5 after grant.
- wr_gnt_i held low 3 cycles during WRITE → wr_req_o, wr_addr_o and wr_codeword_o stable for 4 cycles; single write on grant.
- Core write to addr 5 during WRITE for addr 5 → wr_req_o drops; no count; pointer advances to 6.
- core_rd_busy_i high 5 cycles at READ → no sample; the read completes in the first free cycle with the same address.
- rst asserted during WRITE → next cycle all outputs 0, state IDLE, pointer 1, err_count_o=0.
